// File: rtl/dual_priority_front.sv
// Purpose: debounced two-level priority front end; reports the highest and second-highest active request.
// Latency: 2 clk sync + DEB_TICKS stable tick periods + 1 clk encode register (<= 3 + (DEB_TICKS+1)*TICK_DIV clk).
// Backpressure: none; outputs are free-running registers and single-cycle pulses.
//
// Ports:
//   clk      single clock, all state on rising edge
//   rst_n    synchronous active-low reset
//   req_in   raw asynchronous request lines, higher index = higher priority
//   num1     {valid, idx[3:0]} of the highest accepted request
//   num2     {valid, idx[3:0]} of the second-highest accepted request
//   tick     one-clk timebase pulse every TICK_DIV clocks
//   changed  one-clk pulse in the cycle num1/num2 take a new value
module dual_priority_front #(
    parameter int REQ_WIDTH = 12,
    parameter int TICK_DIV  = 100000,
    parameter int DEB_TICKS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQ_WIDTH-1:0] req_in,
    output logic [4:0]           num1,
    output logic [4:0]           num2,
    output logic                 tick,
    output logic                 changed
);

    localparam int TCW = $clog2(TICK_DIV);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [7:0]     DEB_LAST  = 8'(DEB_TICKS - 1);

    logic [TCW-1:0]       tick_cnt;
    logic [REQ_WIDTH-1:0] sync1;
    logic [REQ_WIDTH-1:0] sync2;
    logic [REQ_WIDTH-1:0] sync_prev;
    logic [REQ_WIDTH-1:0] deb;
    logic [7:0]           stab_cnt;
    logic [3:0]           hi1;
    logic [3:0]           hi2;
    logic                 hi1_vld;
    logic                 hi2_vld;
    logic [4:0]           nxt1;
    logic [4:0]           nxt2;

    // Timebase: tick is decoded from the counter so it lands in the cycle
    // the counter sits at its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Synchronizer plus debouncer. sync_prev holds last cycle's synchronized
    // value so any movement of the pattern restarts the stability count; a
    // change coinciding with a tick therefore never increments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
            deb       <= '0;
            stab_cnt  <= '0;
        end else begin
            sync1     <= req_in;
            sync2     <= sync1;
            sync_prev <= sync2;
            if ((sync2 != sync_prev) || (sync2 == deb)) begin
                stab_cnt <= '0;
            end else if (tick) begin
                if (stab_cnt == DEB_LAST) begin
                    deb      <= sync2;
                    stab_cnt <= '0;
                end else begin
                    stab_cnt <= stab_cnt + 1'b1;
                end
            end
        end
    end

    // Priority encoder: ascending scans so the last hit is the highest index.
    always_comb begin
        hi1     = '0;
        hi1_vld = 1'b0;
        hi2     = '0;
        hi2_vld = 1'b0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (deb[i]) begin
                hi1     = 4'(i);
                hi1_vld = 1'b1;
            end
        end
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (deb[i] && (4'(i) != hi1)) begin
                hi2     = 4'(i);
                hi2_vld = 1'b1;
            end
        end
        nxt1 = hi1_vld ? {1'b1, hi1} : 5'b0_0000;
        nxt2 = hi2_vld ? {1'b1, hi2} : 5'b0_0000;
    end

    // changed is registered with the numbers so it coincides with the update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num1    <= 5'b0_0000;
            num2    <= 5'b0_0000;
            changed <= 1'b0;
        end else begin
            num1    <= nxt1;
            num2    <= nxt2;
            changed <= (nxt1 != num1) || (nxt2 != num2);
        end
    end

endmodule
